// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: GPRs, PC/IR/MAR/MDR/HI/LO/Y/Z and a combinational ALU.
// One-cycle register transfers; DATAPATH_MULDIV_EN builds the signed multiplier/divider.
module datapath (
    input  logic        clk,
    input  logic        reset,
    input  logic        R0out,
    input  logic        R1out,
    input  logic        R2out,
    input  logic        R3out,
    input  logic        R4out,
    input  logic        R5out,
    input  logic        R6out,
    input  logic        R7out,
    input  logic        R8out,
    input  logic        R9out,
    input  logic        R10out,
    input  logic        R11out,
    input  logic        R12out,
    input  logic        R13out,
    input  logic        R14out,
    input  logic        R15out,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        Zhighout,
    input  logic        Zlowout,
    input  logic        PCout,
    input  logic        IRout,
    input  logic        MDRout,
    input  logic        INout,
    input  logic        Cout,
    input  logic        Yout,
    input  logic        MARout,
    input  logic        Read,
    input  logic        IncPC,
    input  logic        AND,
    input  logic        OR,
    input  logic        ADD,
    input  logic        SUB,
    input  logic        MUL,
    input  logic        DIV,
    input  logic        SHR,
    input  logic        SHRA,
    input  logic        SHL,
    input  logic        ROR,
    input  logic        ROL,
    input  logic        NEG,
    input  logic        NOT,
    input  logic        R0in,
    input  logic        R1in,
    input  logic        R2in,
    input  logic        R3in,
    input  logic        R4in,
    input  logic        R5in,
    input  logic        R6in,
    input  logic        R7in,
    input  logic        R8in,
    input  logic        R9in,
    input  logic        R10in,
    input  logic        R11in,
    input  logic        R12in,
    input  logic        R13in,
    input  logic        R14in,
    input  logic        R15in,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        PCin,
    input  logic        IRin,
    input  logic        Zin,
    input  logic        Yin,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic [31:0] IN,
    output logic [31:0] BusMuxOut,
    output logic [31:0] PC
);

    logic [31:0] gpr_q [16];
    logic [31:0] hi_q, lo_q, pc_q, ir_q, mar_q, mdr_q, y_q;
    logic [63:0] z_q;
    logic [31:0] pc_d, mdr_d;
    logic [63:0] z_d;

    logic [15:0] r_out, r_in;
    logic [31:0] bus;
    logic [31:0] c_sext;

    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
    assign r_in  = {R15in,  R14in,  R13in,  R12in,  R11in,  R10in,  R9in,  R8in,
                    R7in,   R6in,   R5in,   R4in,   R3in,   R2in,   R1in,  R0in};

    assign c_sext = {{13{ir_q[18]}}, ir_q[18:0]};

    // Lowest-priority source is applied first so the highest-priority one lands last.
    always_comb begin
        bus = '0;
        if (IRout)    bus = ir_q;
        if (MARout)   bus = mar_q;
        if (Yout)     bus = y_q;
        if (Cout)     bus = c_sext;
        if (INout)    bus = IN;
        if (MDRout)   bus = mdr_q;
        if (PCout)    bus = pc_q;
        if (Zlowout)  bus = z_q[31:0];
        if (Zhighout) bus = z_q[63:32];
        if (LOout)    bus = lo_q;
        if (HIout)    bus = hi_q;
        for (int i = 15; i >= 0; i--) begin
            if (r_out[i]) bus = gpr_q[i];
        end
    end

    assign BusMuxOut = bus;
    assign PC        = pc_q;

    logic [4:0]         shamt;
    logic signed [31:0] y_s;
    logic [31:0]        sra_res;
    logic [63:0]        rot_r, rot_l;
    logic [63:0]        mul_res, div_res;

    assign shamt   = bus[4:0];
    assign y_s     = y_q;
    assign sra_res = y_s >>> shamt;
    assign rot_r   = {y_q, y_q} >> shamt;
    assign rot_l   = {y_q, y_q} << shamt;

`ifdef DATAPATH_MULDIV_EN
    logic signed [63:0] prod;
    logic signed [31:0] quot, rem;

    assign prod = $signed({{32{y_q[31]}}, y_q}) * $signed({{32{bus[31]}}, bus});

    // Divide-by-zero yields an all-ones quotient and passes the dividend through as remainder.
    always_comb begin
        quot = '1;
        rem  = y_s;
        if (bus != 32'd0) begin
            quot = y_s / $signed(bus);
            rem  = y_s % $signed(bus);
        end
    end

    assign mul_res = prod;
    assign div_res = {rem, quot};
`else
    assign mul_res = '0;
    assign div_res = '0;
`endif

    always_comb begin
        z_d = '0;
        if (NOT)  z_d = {32'd0, ~bus};
        if (NEG)  z_d = {32'd0, 32'd0 - bus};
        if (ROL)  z_d = {32'd0, rot_l[63:32]};
        if (ROR)  z_d = {32'd0, rot_r[31:0]};
        if (SHL)  z_d = {32'd0, y_q << shamt};
        if (SHRA) z_d = {32'd0, sra_res};
        if (SHR)  z_d = {32'd0, y_q >> shamt};
        if (DIV)  z_d = div_res;
        if (MUL)  z_d = mul_res;
        if (SUB)  z_d = {32'd0, y_q - bus};
        if (ADD)  z_d = {32'd0, y_q + bus};
        if (OR)   z_d = {32'd0, y_q | bus};
        if (AND)  z_d = {32'd0, y_q & bus};
    end

    assign pc_d  = IncPC ? pc_q + 32'd1 : bus;
    assign mdr_d = Read  ? IN           : bus;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) gpr_q[i] <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            z_q   <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (r_in[i]) gpr_q[i] <= bus;
            end
            if (HIin)  hi_q  <= bus;
            if (LOin)  lo_q  <= bus;
            if (PCin)  pc_q  <= pc_d;
            if (IRin)  ir_q  <= bus;
            if (MARin) mar_q <= bus;
            if (MDRin) mdr_q <= mdr_d;
            if (Yin)   y_q   <= bus;
            if (Zin)   z_q   <= z_d;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Directed-vector bench for datapath; registers are observed by driving them onto the bus.
module tb_datapath;

    localparam int OP_AND = 0, OP_OR = 1, OP_ADD = 2, OP_SUB = 3, OP_MUL = 4, OP_DIV = 5,
                   OP_SHR = 6, OP_SHRA = 7, OP_SHL = 8, OP_ROR = 9, OP_ROL = 10,
                   OP_NEG = 11, OP_NOT = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] rout, rin;
    logic [12:0] op;
    logic        HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout, Cout, Yout, MARout;
    logic        Read, IncPC;
    logic        HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin;
    logic [31:0] IN;
    logic [31:0] BusMuxOut, PC;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    datapath dut (
        .clk(clk), .reset(reset),
        .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
        .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
        .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .PCout(PCout), .IRout(IRout), .MDRout(MDRout), .INout(INout), .Cout(Cout),
        .Yout(Yout), .MARout(MARout), .Read(Read), .IncPC(IncPC),
        .AND(op[OP_AND]), .OR(op[OP_OR]), .ADD(op[OP_ADD]), .SUB(op[OP_SUB]),
        .MUL(op[OP_MUL]), .DIV(op[OP_DIV]), .SHR(op[OP_SHR]), .SHRA(op[OP_SHRA]),
        .SHL(op[OP_SHL]), .ROR(op[OP_ROR]), .ROL(op[OP_ROL]), .NEG(op[OP_NEG]),
        .NOT(op[OP_NOT]),
        .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
        .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
        .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .Zin(Zin), .Yin(Yin),
        .MARin(MARin), .MDRin(MDRin), .IN(IN),
        .BusMuxOut(BusMuxOut), .PC(PC)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic clr();
        reset = 1'b0; rout = '0; rin = '0; op = '0;
        HIout = 0; LOout = 0; Zhighout = 0; Zlowout = 0; PCout = 0; IRout = 0;
        MDRout = 0; INout = 0; Cout = 0; Yout = 0; MARout = 0;
        Read = 0; IncPC = 0;
        HIin = 0; LOin = 0; PCin = 0; IRin = 0; Zin = 0; Yin = 0; MARin = 0; MDRin = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic chk_r(input string tag, input int n, input logic [31:0] exp);
        rout[n] = 1'b1;
        #1;
        check(tag, BusMuxOut, exp);
        rout[n] = 1'b0;
    endtask

    task automatic load_r(input int n, input logic [31:0] v);
        IN = v; INout = 1; rin[n] = 1;
        tick();
    endtask

    task automatic alu_run(input int opi, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] z);
        IN = a; INout = 1; Yin = 1;
        tick();
        IN = b; INout = 1; op[opi] = 1'b1; Zin = 1;
        tick();
        Zlowout = 1; #1; z[31:0] = BusMuxOut; Zlowout = 0;
        Zhighout = 1; #1; z[63:32] = BusMuxOut; Zhighout = 0;
    endtask

    task automatic alu_chk(input string tag, input int opi, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
        logic [63:0] z;
        alu_run(opi, a, b, z);
        check({tag, ".lo"}, z[31:0], exp[31:0]);
        check({tag, ".hi"}, z[63:32], exp[63:32]);
    endtask

    initial begin
        clr();
        IN = '0;

        // Reset with PCin held high
        reset = 1; PCin = 1;
        tick();
        check("rst.pc", PC, 32'h0);
        check("rst.bus", BusMuxOut, 32'h0);
        chk_r("rst.r3", 3, 32'h0);
        Zlowout = 1; #1; check("rst.zlo", BusMuxOut, 32'h0); Zlowout = 0;
        MDRout = 1;  #1; check("rst.mdr", BusMuxOut, 32'h0); MDRout = 0;

        // Register loads through MDR
        IN = 32'h22; Read = 1; MDRin = 1; tick();
        MDRout = 1; #1; check("mdr.22", BusMuxOut, 32'h22); rin[3] = 1; tick();
        chk_r("r3.load", 3, 32'h22);
        IN = 32'h24; Read = 1; MDRin = 1; tick();
        MDRout = 1; rin[7] = 1; tick();
        IN = 32'h28; Read = 1; MDRin = 1; tick();
        MDRout = 1; rin[4] = 1; tick();
        chk_r("r7.load", 7, 32'h24);
        chk_r("r4.load", 4, 32'h28);

        // Fetch then ADD R4 = R3 + R7
        IN = 32'h1A1B8000; IncPC = 1; PCin = 1; MARin = 1; MDRin = 1; Read = 1; tick();
        check("t0.pc", PC, 32'h1);
        MDRout = 1; #1; check("t0.mdr", BusMuxOut, 32'h1A1B8000);
        IRin = 1; tick();
        IRout = 1; #1; check("t1.ir", BusMuxOut, 32'h1A1B8000); IRout = 0;
        Cout = 1;  #1; check("c.sext", BusMuxOut, 32'h00038000); Cout = 0;
        rout[3] = 1; Yin = 1; tick();
        Yout = 1; #1; check("t2.y", BusMuxOut, 32'h22); Yout = 0;
        rout[7] = 1; op[OP_ADD] = 1; Zin = 1; tick();
        Zlowout = 1; #1; check("t3.zlo", BusMuxOut, 32'h46); Zlowout = 0;
        Zhighout = 1; #1; check("t3.zhi", BusMuxOut, 32'h0); Zhighout = 0;
        Zlowout = 1; rin[4] = 1; tick();
        chk_r("t4.r4", 4, 32'h46);

        // Negative IR immediate
        IN = 32'h0007FFFF; INout = 1; IRin = 1; tick();
        Cout = 1; #1; check("c.neg", BusMuxOut, 32'hFFFFFFFF); Cout = 0;

`ifdef DATAPATH_MULDIV_EN
        alu_chk("mul",  OP_MUL, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA);
        alu_chk("div",  OP_DIV, 32'd7, 32'd2, {32'd1, 32'd3});
        alu_chk("div0", OP_DIV, 32'd7, 32'd0, {32'd7, 32'hFFFFFFFF});
        alu_chk("divn", OP_DIV, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
`else
        alu_chk("mul",  OP_MUL, 32'hFFFFFFFE, 32'd3, 64'h0);
        alu_chk("div",  OP_DIV, 32'd7, 32'd2, 64'h0);
`endif

        alu_chk("shra", OP_SHRA, 32'h80000001, 32'd1, 64'hC0000000);
        alu_chk("shr",  OP_SHR,  32'h80000001, 32'd1, 64'h40000000);
        alu_chk("ror",  OP_ROR,  32'h80000001, 32'd1, 64'hC0000000);
        alu_chk("rol",  OP_ROL,  32'h80000001, 32'd1, 64'h00000003);
        alu_chk("shl",  OP_SHL,  32'h80000001, 32'd1, 64'h00000002);
        alu_chk("ror0", OP_ROR,  32'h12345678, 32'd32, 64'h12345678);
        alu_chk("sub",  OP_SUB,  32'd5, 32'd7, 64'hFFFFFFFE);
        alu_chk("neg",  OP_NEG,  32'd9, 32'd1, 64'hFFFFFFFF);
        alu_chk("not",  OP_NOT,  32'd9, 32'h0F0F0000, 64'hF0F0FFFF);
        alu_chk("and",  OP_AND,  32'hC, 32'hA, 64'h8);
        alu_chk("or",   OP_OR,   32'hC, 32'hA, 64'hE);
        alu_chk("addw", OP_ADD,  32'hFFFFFFFF, 32'd2, 64'h1);

        // AND outranks ADD; no op gives zero
        IN = 32'hC; INout = 1; Yin = 1; tick();
        IN = 32'hA; INout = 1; op[OP_AND] = 1; op[OP_ADD] = 1; Zin = 1; tick();
        Zlowout = 1; #1; check("oppri", BusMuxOut, 32'h8); Zlowout = 0;
        IN = 32'hA; INout = 1; Zin = 1; tick();
        Zlowout = 1; #1; check("noop", BusMuxOut, 32'h0); Zlowout = 0;

        // Yin and Zin together: Z sees the old Y
        IN = 32'd5; INout = 1; Yin = 1; tick();
        IN = 32'd3; INout = 1; Yin = 1; op[OP_ADD] = 1; Zin = 1; tick();
        Zlowout = 1; #1; check("oldy.z", BusMuxOut, 32'd8); Zlowout = 0;
        Yout = 1; #1; check("oldy.y", BusMuxOut, 32'd3); Yout = 0;

        // Bus priority
        load_r(1, 32'h11);
        load_r(2, 32'h2222);
        IN = 32'h3; INout = 1; HIin = 1; tick();
        rout[1] = 1; rout[2] = 1; #1; check("pri.r1r2", BusMuxOut, 32'h11);
        rout = '0; rout[2] = 1; HIout = 1; #1; check("pri.r2hi", BusMuxOut, 32'h2222);
        rout = '0; INout = 1; IN = 32'h99; #1; check("pri.hiin", BusMuxOut, 32'h3);
        clr(); #1; check("pri.none", BusMuxOut, 32'h0);
        rout[1] = 1; rin[1] = 1; tick();
        chk_r("self.r1", 1, 32'h11);

        // PC wrap
        IN = 32'hFFFFFFFF; INout = 1; PCin = 1; tick();
        check("pc.load", PC, 32'hFFFFFFFF);
        IN = 32'h1234; INout = 1; IncPC = 1; PCin = 1; tick();
        check("pc.wrap", PC, 32'h0);

        // Reset overrides loads
        reset = 1; IN = 32'h55; INout = 1; PCin = 1; rin[3] = 1; tick();
        check("rst2.pc", PC, 32'h0);
        chk_r("rst2.r3", 3, 32'h0);
        chk_r("rst2.r1", 1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
